// File: rtl/sigmoid_lut_loader.sv
// Writer side of the sigmoid LUT: streams S7.8 words into the table, gates use with lut_valid.
// Optional per-word range/monotonicity checking is enabled by defining SIGMOID_LUT_CHECK_EN.
module sigmoid_lut_loader #(
  parameter int WIDTH      = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  lut_valid,
  output logic                  error,
  output logic [WIDTH-1:0]      checksum
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      checksum_q;
  logic [WIDTH-1:0]      rd_data_q;
  logic                  wr_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  lut_valid_q;
  logic                  error_q;
  logic                  error_d;
  logic                  beat;

  logic [WIDTH-1:0]      mem_q [DEPTH];

  assign beat = wr_valid & wr_ready_q;

`ifdef SIGMOID_LUT_CHECK_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC_BITS;

  logic [WIDTH-1:0] prev_q;
  logic             bad_word;

  // The first word of a load has no predecessor, so only the range check applies to it.
  always_comb begin
    bad_word = wr_data[WIDTH-1] | (wr_data > ONE);
    if ((addr_q != '0) && ($signed(wr_data) < $signed(prev_q))) begin
      bad_word = 1'b1;
    end
  end

  assign error_d = error_q | (beat & bad_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else if ((state_q != LOAD) && start) begin
      prev_q <= '0;
    end else if (beat) begin
      prev_q <= wr_data;
    end
  end
`else
  assign error_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      checksum_q  <= '0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lut_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= LOAD;
            addr_q      <= '0;
            checksum_q  <= '0;
            error_q     <= 1'b0;
            wr_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            lut_valid_q <= 1'b0;
          end
        end
        LOAD: begin
          // start is deliberately ignored here, even alongside the final beat.
          if (beat) begin
            addr_q     <= addr_q + 1'b1;
            checksum_q <= checksum_q + wr_data;
            error_q    <= error_d;
            if (&addr_q) begin
              state_q     <= DONE;
              wr_ready_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              lut_valid_q <= ~error_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Table storage is never cleared; a beat landing in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (beat && !rst) begin
      mem_q[addr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lut_valid = lut_valid_q;
  assign error     = error_q;
  assign checksum  = checksum_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_sigmoid_lut_loader.sv
// Directed self-checking bench for sigmoid_lut_loader at a 16-entry table.
module tb_sigmoid_lut_loader;

  localparam int WIDTH = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

`ifdef SIGMOID_LUT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             lut_valid;
  logic             error;
  logic [WIDTH-1:0] checksum;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] vec [DEPTH];

  sigmoid_lut_loader #(.WIDTH(WIDTH), .FRAC_BITS(8), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .lut_valid (lut_valid),
    .error     (error),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_base();
    for (int i = 0; i < DEPTH; i++) vec[i] = 16'h0080 + 16'(8 * i);
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feeds vec[first..last]; ready_cycles counts cycles with wr_ready seen high.
  task automatic feed(input int first, input int last, input bit toggle, input bit hold_start,
                      output int cycles, output int ready_cycles);
    int i;
    int cyc;
    i = first;
    cyc = 0;
    ready_cycles = 0;
    while (i <= last && cyc < 200) begin
      start    = hold_start;
      wr_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      wr_data  = vec[i];
      if (wr_ready) ready_cycles++;
      if (wr_ready && wr_valid) i++;
      tick();
      cyc++;
    end
    wr_valid = 1'b0;
    start    = 1'b0;
    if (i <= last) chk("feed_timeout", i, last + 1);
    cycles = cyc;
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      tick();
      chk(tag, rd_data, vec[i]);
    end
  endtask

  initial begin
    int cyc;
    int rdy;

    rst = 1'b1; start = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_addr = '0;
    tick();
    tick();
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lut_valid", lut_valid, 0);
    chk("rst_error", error, 0);
    chk("rst_checksum", checksum, 0);

    // Test 1: back-to-back load
    set_base();
    start_load();
    chk("t1_busy", busy, 1);
    chk("t1_ready", wr_ready, 1);
    feed(0, 15, 1'b0, 1'b0, cyc, rdy);
    chk("t1_cycles", cyc, 16);
    chk("t1_ready_cycles", rdy, 16);
    chk("t1_done", done, 1);
    chk("t1_lut_valid", lut_valid, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_ready_end", wr_ready, 0);
    chk("t1_checksum", checksum, 16'h0BC0);
    rd_addr = 4'd5;
    tick();
    chk("t1_rd5", rd_data, 16'h00A8);

    // Test 2: alternating valid, start held throughout (must be ignored in LOAD)
    start_load();
    feed(0, 15, 1'b1, 1'b1, cyc, rdy);
    chk("t2_cycles", cyc, 31);
    chk("t2_ready_cycles", rdy, 31);
    chk("t2_done", done, 1);
    chk("t2_checksum", checksum, 16'h0BC0);
    tick();
    chk("t2_done_hold", done, 1);
    chk("t2_busy_hold", busy, 0);
    readback("t2_mem");

    // Test 3: reset mid-load, then a clean reload
    start_load();
    feed(0, 6, 1'b0, 1'b0, cyc, rdy);
    chk("t3_partial_sum", checksum, 16'h0428);
    chk("t3_busy_mid", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t3_busy", busy, 0);
    chk("t3_done", done, 0);
    chk("t3_lut_valid", lut_valid, 0);
    chk("t3_checksum", checksum, 0);
    chk("t3_ready", wr_ready, 0);
    start_load();
    feed(0, 15, 1'b0, 1'b0, cyc, rdy);
    chk("t3_done_reload", done, 1);
    chk("t3_lut_reload", lut_valid, 1);
    chk("t3_sum_reload", checksum, 16'h0BC0);

    // Test 4: monotonicity violation (0x0060 after 0x0098)
    set_base();
    vec[4] = 16'h0060;
    start_load();
    feed(0, 4, 1'b0, 1'b0, cyc, rdy);
    chk("t4_err_next", error, CHK);
    feed(5, 15, 1'b0, 1'b0, cyc, rdy);
    chk("t4_done", done, 1);
    chk("t4_err_end", error, CHK);
    chk("t4_lut_valid", lut_valid, !CHK);
    chk("t4_checksum", checksum, 16'h0B80);
    start_load();
    chk("t4_err_clr", error, 0);
    chk("t4_done_clr", done, 0);
    chk("t4_lut_clr", lut_valid, 0);
    set_base();
    feed(0, 15, 1'b0, 1'b0, cyc, rdy);
    chk("t4_lut_reload", lut_valid, 1);

    // Test 5: range violation on last word, then exactly ONE is accepted
    vec[15] = 16'h0101;
    start_load();
    feed(0, 15, 1'b0, 1'b0, cyc, rdy);
    chk("t5_err", error, CHK);
    chk("t5_lut_valid", lut_valid, !CHK);
    chk("t5_checksum", checksum, 16'h0BC9);
    vec[15] = 16'h0100;
    start_load();
    feed(0, 15, 1'b0, 1'b0, cyc, rdy);
    chk("t5_one_err", error, 0);
    chk("t5_one_lut", lut_valid, 1);
    chk("t5_one_sum", checksum, 16'h0BC8);

    // Test 6: restart from DONE while reading, then write-vs-read ordering
    rd_addr = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_lut_drop", lut_valid, 0);
    chk("t6_rd_old", rd_data, 16'h0080);
    wr_data  = 16'h0010;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("t6_rd_same_cycle", rd_data, 16'h0080);
    tick();
    chk("t6_rd_new", rd_data, 16'h0010);
    chk("t6_checksum", checksum, 16'h0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
